adder_chk: RTL and testbench

//   Hardware receiver/checker on the add_if bus of the registered adder: samples a/b/rst stimulus each

---
 rtl/adder_chk_pkg.sv | 22 ++
 rtl/adder_chk_if.sv | 15 +
 rtl/adder_chk_dly.sv | 43 ++++
 rtl/adder_chk.sv | 161 ++++++++++++++++
 tb/tb_adder_chk.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/adder_chk_pkg.sv
// Shared types and default widths for the adder_chk receiver/checker.
package adder_chk_pkg;

    localparam int unsigned DefW    = 4;
    localparam int unsigned DefLat  = 1;
    localparam int unsigned DefCntW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    // Default-width view of one delay-line entry; the top redeclares it for its own W.
    typedef struct packed {
        logic            vld;
        logic [DefW-1:0] a;
        logic [DefW-1:0] b;
        logic [DefW:0]   exp;
    } exp_entry_t;

endpackage

// File: rtl/adder_chk_if.sv
// add_if bus between the stimulus driver, the registered adder and the checker.
interface adder_chk_if #(
    parameter int unsigned W = 4
) ();

    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         dut_rst;
    logic [W:0]   y;

    modport master (output a, b, dut_rst, input y);
    modport slave  (input a, b, dut_rst, output y);
    modport mon    (input a, b, dut_rst, y);

endinterface

// File: rtl/adder_chk_dly.sv
// Lat-stage shift line of packed entries; the MSB is the valid bit, cleared by flush_i.
module adder_chk_dly #(
    parameter int unsigned Lat   = 1,
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    logic [Width-1:0] stage_q [Lat];
    logic [Width-1:0] stage_d [Lat];

    always_comb begin
        stage_d[0] = data_i;
        for (int unsigned i = 1; i < Lat; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        // Flush also kills the entry being shifted in on the same edge.
        if (flush_i) begin
            for (int unsigned i = 0; i < Lat; i++) begin
                stage_d[i][Width-1] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < Lat; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < Lat; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign data_o = stage_q[Lat-1];

endmodule

// File: rtl/adder_chk.sv
// Golden monitor for the registered adder: predicts y, compares LAT cycles later, counts results.
// Optional first-mismatch capture outputs when ADDCHK_FIRST_ERR_CAPTURE_EN is defined.
module adder_chk
    import adder_chk_pkg::*;
#(
    parameter int unsigned W     = DefW,
    parameter int unsigned LAT   = DefLat,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             halt_on_err_i,
    adder_chk_if.mon         bus,
    output logic             busy_o,
    output logic             mismatch_o,
    output logic             err_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [1:0]       state_o
`ifdef ADDCHK_FIRST_ERR_CAPTURE_EN
    ,
    output logic [W-1:0]     cap_a_o,
    output logic [W-1:0]     cap_b_o,
    output logic [W:0]       cap_exp_o,
    output logic [W:0]       cap_y_o,
    output logic             cap_vld_o
`endif
);

    typedef struct packed {
        logic         vld;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp;
    } entry_t;

    state_t           state_q, state_d;
    entry_t           head, tail;
    logic             start_eff, cmp_ok, cmp_bad;
    logic [CNT_W-1:0] pass_q, pass_d, errc_q, errc_d;
    logic             err_q, err_d, mis_q, mis_d;

    // Stop has priority over a simultaneous start.
    assign start_eff = start_i & ~stop_i;

    always_comb begin
        head.vld = (state_q == ST_RUN);
        head.a   = bus.a;
        head.b   = bus.b;
        head.exp = bus.dut_rst ? '0 : ({1'b0, bus.a} + {1'b0, bus.b});
    end

    adder_chk_dly #(
        .Lat   (LAT),
        .Width ($bits(entry_t))
    ) u_dly (
        .clk     (clk),
        .rst     (rst),
        .flush_i (start_eff),
        .data_i  (head),
        .data_o  (tail)
    );

    // Case equality makes X/Z on y a mismatch in simulation; synthesis reduces it to ==.
    assign cmp_ok  = (bus.y === tail.exp);
    assign cmp_bad = tail.vld & ~cmp_ok;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_eff) state_d = ST_RUN;
            ST_RUN: begin
                if (stop_i)                          state_d = ST_IDLE;
                else if (start_eff)                  state_d = ST_RUN;
                else if (cmp_bad && halt_on_err_i)   state_d = ST_FAIL;
            end
            ST_FAIL: begin
                if (stop_i)         state_d = ST_IDLE;
                else if (start_eff) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pass_d = pass_q;
        errc_d = errc_q;
        err_d  = err_q;
        mis_d  = 1'b0;
        if (start_eff) begin
            pass_d = '0;
            errc_d = '0;
            err_d  = 1'b0;
        end else if (tail.vld) begin
            if (cmp_ok) begin
                if (pass_q != '1) pass_d = pass_q + 1'b1;
            end else begin
                if (errc_q != '1) errc_d = errc_q + 1'b1;
                err_d = 1'b1;
                mis_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pass_q  <= '0;
            errc_q  <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            errc_q  <= errc_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    assign busy_o     = (state_q == ST_RUN);
    assign mismatch_o = mis_q;
    assign err_o      = err_q;
    assign pass_cnt_o = pass_q;
    assign err_cnt_o  = errc_q;
    assign state_o    = state_q;

`ifdef ADDCHK_FIRST_ERR_CAPTURE_EN
    logic [W-1:0] cap_a_q, cap_b_q;
    logic [W:0]   cap_exp_q, cap_y_q;
    logic         cap_vld_q;

    always_ff @(posedge clk) begin
        if (rst || start_eff) begin
            cap_a_q   <= '0;
            cap_b_q   <= '0;
            cap_exp_q <= '0;
            cap_y_q   <= '0;
            cap_vld_q <= 1'b0;
        end else if (cmp_bad && !cap_vld_q) begin
            cap_a_q   <= tail.a;
            cap_b_q   <= tail.b;
            cap_exp_q <= tail.exp;
            cap_y_q   <= bus.y;
            cap_vld_q <= 1'b1;
        end
    end

    assign cap_a_o   = cap_a_q;
    assign cap_b_o   = cap_b_q;
    assign cap_exp_o = cap_exp_q;
    assign cap_y_o   = cap_y_q;
    assign cap_vld_o = cap_vld_q;
`else
    logic unused_tail_ops;
    assign unused_tail_ops = ^{tail.a, tail.b};
`endif

endmodule

// File: tb/tb_adder_chk.sv
// Self-checking bench for adder_chk: directed scenarios then random traffic against a queue model.
// Two checkers (CNT_W=16 and CNT_W=2) watch the same bus to exercise counter saturation.
module tb_adder_chk;

    localparam int unsigned W   = 4;
    localparam int unsigned LAT = 1;

    logic clk = 1'b0;
    logic rst, start, stop, halt;

    adder_chk_if #(.W(W)) bus ();

    logic        busy16, mis16, err16, busy2, mis2, err2;
    logic [15:0] pass16, errc16;
    logic [1:0]  pass2, errc2, st16, st2;

`ifdef ADDCHK_FIRST_ERR_CAPTURE_EN
    logic [W-1:0] cap_a16, cap_b16, cap_a2, cap_b2;
    logic [W:0]   cap_e16, cap_y16, cap_e2, cap_y2;
    logic         cap_v16, cap_v2;
`endif

    adder_chk #(.W(W), .LAT(LAT), .CNT_W(16)) u_chk16 (
        .clk (clk), .rst (rst), .start_i (start), .stop_i (stop), .halt_on_err_i (halt),
        .bus (bus), .busy_o (busy16), .mismatch_o (mis16), .err_o (err16),
        .pass_cnt_o (pass16), .err_cnt_o (errc16), .state_o (st16)
`ifdef ADDCHK_FIRST_ERR_CAPTURE_EN
        , .cap_a_o (cap_a16), .cap_b_o (cap_b16), .cap_exp_o (cap_e16), .cap_y_o (cap_y16),
        .cap_vld_o (cap_v16)
`endif
    );

    adder_chk #(.W(W), .LAT(LAT), .CNT_W(2)) u_chk2 (
        .clk (clk), .rst (rst), .start_i (start), .stop_i (stop), .halt_on_err_i (halt),
        .bus (bus), .busy_o (busy2), .mismatch_o (mis2), .err_o (err2),
        .pass_cnt_o (pass2), .err_cnt_o (errc2), .state_o (st2)
`ifdef ADDCHK_FIRST_ERR_CAPTURE_EN
        , .cap_a_o (cap_a2), .cap_b_o (cap_b2), .cap_exp_o (cap_e2), .cap_y_o (cap_y2),
        .cap_vld_o (cap_v2)
`endif
    );

    always #5 clk = ~clk;

    // Model: pending compares keyed by the cycle in which y must match; unbounded counts.
    typedef struct {
        int           due;
        logic [W:0]   exp;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pend_t;

    pend_t      pend_q[$];
    int         mode, npass, nerr, cyc;
    bit         merr, mmis;
    logic [W:0] adder_q;
    int         n_chk, n_fail;
    bit         cap_v;
    logic [W:0] cap_e, cap_y;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // One clock cycle: drive at negedge, update model at posedge, compare #1 later.
    task automatic step(input bit st, input bit sp, input bit hlt, input bit r,
                        input logic [W-1:0] a, input logic [W-1:0] b, input bit dr,
                        input bit ovr, input logic [W:0] yv);
        logic [W:0] ydrv;
        bit         bad, cmp;
        int         old;
        pend_t      e;
        @(negedge clk);
        rst = r; start = st; stop = sp; halt = hlt;
        bus.a = a; bus.b = b; bus.dut_rst = dr;
        ydrv  = ovr ? yv : adder_q;
        bus.y = ydrv;
        @(posedge clk);
        adder_q = dr ? '0 : (W+1)'(int'(a) + int'(b));
        if (r) begin
            mode = 0; npass = 0; nerr = 0; merr = 0; mmis = 0; cap_v = 0;
            cap_e = '0; cap_y = '0;
            pend_q.delete();
        end else begin
            cmp = 0; bad = 0; mmis = 0; old = mode;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                e   = pend_q.pop_front();
                cmp = 1;
                bad = (ydrv !== e.exp);
            end
            if (st && !sp) begin
                npass = 0; nerr = 0; merr = 0; mode = 1; cap_v = 0;
                cap_e = '0; cap_y = '0;
                pend_q.delete();
            end else begin
                if (cmp && bad) begin
                    nerr++; merr = 1; mmis = 1;
                    if (!cap_v) begin cap_v = 1; cap_e = e.exp; cap_y = ydrv; end
                end else if (cmp) begin
                    npass++;
                end
                if (old == 1)
                    pend_q.push_back('{cyc + LAT, dr ? '0 : (W+1)'(int'(a) + int'(b)), a, b});
                if (sp) mode = 0;
                else if (old == 1 && bad && hlt) mode = 2;
            end
        end
        cyc++;
        #1;
        check("state", 32'(st16), 32'(mode));
        check("busy", 32'(busy16), 32'(mode == 1));
        check("mismatch", 32'(mis16), 32'(mmis));
        check("err", 32'(err16), 32'(merr));
        check("pass_cnt", 32'(pass16), 32'(sat(npass, 65535)));
        check("err_cnt", 32'(errc16), 32'(sat(nerr, 65535)));
        check("pass_cnt_w2", 32'(pass2), 32'(sat(npass, 3)));
        check("err_cnt_w2", 32'(errc2), 32'(sat(nerr, 3)));
        check("state_w2", 32'(st2), 32'(mode));
`ifdef ADDCHK_FIRST_ERR_CAPTURE_EN
        check("cap_vld", 32'(cap_v16), 32'(cap_v));
        check("cap_exp", 32'(cap_e16), 32'(cap_e));
        check("cap_y", 32'(cap_y16), 32'(cap_y));
`endif
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; halt = 0;
        bus.a = '0; bus.b = '0; bus.dut_rst = 0; bus.y = '0;
        adder_q = '0; mode = 0; npass = 0; nerr = 0; merr = 0; mmis = 0; cyc = 0;
        cap_v = 0; cap_e = '0; cap_y = '0;
        n_chk = 0; n_fail = 0;

        repeat (3) step(0, 0, 0, 1, 0, 0, 0, 0, '0);

        // Correct adder: 3+4 and 15+15.
        step(1, 0, 0, 0, 0, 0, 0, 0, '0);
        step(0, 0, 0, 0, 3, 4, 0, 0, '0);
        step(0, 0, 0, 0, 15, 15, 0, 0, '0);
        step(0, 0, 0, 0, 0, 0, 0, 0, '0);
        check("t1_pass", 32'(pass16), 32'd2);
        check("t1_err", 32'(err16), 32'd0);

        // Forced y=0x10 for 1+1.
        step(0, 0, 0, 0, 1, 1, 0, 0, '0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'h10);
        check("t2_mis", 32'(mis16), 32'd1);
        check("t2_errc", 32'(errc16), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, '0);
        check("t2_mis_drop", 32'(mis16), 32'd0);
        check("t2_sticky", 32'(err16), 32'd1);

        // Halt on error, in-flight bad sample still counted in FAIL, stop holds counts.
        step(0, 0, 1, 0, 2, 3, 0, 0, '0);
        step(0, 0, 1, 0, 5, 6, 0, 1, '0);
        step(0, 0, 1, 0, 0, 0, 0, 1, '0);
        check("t3_fail", 32'(st16), 32'd2);
        check("t3_errc", 32'(errc16), 32'd3);
        step(0, 1, 1, 0, 0, 0, 0, 0, '0);
        check("t3_idle", 32'(st16), 32'd0);
        check("t3_hold", 32'(errc16), 32'd3);

        // DUT held in reset predicts 0.
        step(1, 0, 0, 0, 0, 0, 0, 0, '0);
        step(0, 0, 0, 0, 9, 9, 1, 0, '0);
        step(0, 0, 0, 0, 9, 9, 1, 0, '0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd18);
        check("t4_pass", 32'(pass16), 32'd1);
        check("t4_err", 32'(errc16), 32'd1);

        // Stop with a sample in flight; then start+stop together.
        step(1, 0, 0, 0, 0, 0, 0, 0, '0);
        step(0, 1, 0, 0, 6, 7, 0, 0, '0);
        step(0, 0, 0, 0, 0, 0, 0, 0, '0);
        check("t5_drain", 32'(pass16), 32'd1);
        step(1, 1, 0, 0, 0, 0, 0, 0, '0);
        check("t5_stopwins", 32'(st16), 32'd0);

        // Saturation of the 2-bit checker, then reset mid-run.
        step(1, 0, 0, 0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 4'(i), 4'(i + 3), 0, 0, '0);
        check("t6_sat", 32'(pass2), 32'd3);
        step(0, 0, 0, 1, 7, 7, 0, 0, '0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'h1f);
        check("t6_rst_err", 32'(errc16), 32'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 1) == 0, $urandom_range(0, 79) == 0,
                 4'($urandom), 4'($urandom), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, 5'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
